// File: rtl/fir_seq_ctrl_pkg.sv
// fir_pkg: shared types and constants for the FIR CSR sequencer.
//   state_t         sequencer FSM states
//   ADDR_*          CSR word addresses on the FIR slave port
//   X_W / Y_W       sample and result widths
package fir_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LOAD_LO,
    LOAD_HI,
    GET_X,
    WRITE_X,
    SETTLE,
    READ_REQ,
    READ_CAP,
    PUSH_Y,
    FINISH
  } state_t;

  localparam logic [1:0] ADDR_HLO = 2'd0;
  localparam logic [1:0] ADDR_HHI = 2'd1;
  localparam logic [1:0] ADDR_X   = 2'd2;

  localparam int X_W = 8;
  localparam int Y_W = 24;

endpackage

// File: rtl/fir_seq_ctrl_if.sv
// fir_seq_ctrl_if: CSR port between the sequencer (master) and the FIR block (slave).
//   ChipSelect/Write/Read  strobes, driven by the master
//   Address/WriteData      driven by the master
//   ReadData               driven by the slave, valid one cycle after Read
interface fir_seq_ctrl_if;
  logic        ChipSelect;
  logic        Write;
  logic        Read;
  logic [1:0]  Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (
    output ChipSelect, Write, Read, Address, WriteData,
    input  ReadData
  );

  modport slave (
    input  ChipSelect, Write, Read, Address, WriteData,
    output ReadData
  );
endinterface

// File: rtl/fir_seq_ctrl_timer.sv
// fir_seq_timer: loadable down-counter with terminal-count flag.
//   Load/LoadVal  synchronous load (has priority over counting)
//   Zero          high while the count is 0; the counter holds at 0
module fir_seq_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         RstN,
  input  logic         Load,
  input  logic [W-1:0] LoadVal,
  output logic         Zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge RstN) begin
    if (!RstN) begin
      cnt_q <= '0;
    end else if (Load) begin
      cnt_q <= LoadVal;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign Zero = (cnt_q == '0);

endmodule

// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: sole master on the FIR CSR port. Loads eight taps, then for
// each sample writes X, waits FIR_LAT cycles, reads Yn and hands it downstream.
//   Start/Abort/Busy/Done            job control
//   NumSamples/CoefLo/CoefHi         job parameters, sampled on an accepted Start
//   SampleIn/SampleValid/SampleReady input sample stream
//   YOut/YValid/YReady               result stream
//   csr                              FIR CSR master port
//
// state    | meaning
// IDLE     | waiting for Start
// LOAD_LO  | write taps H3..H0
// LOAD_HI  | write taps H7..H4
// GET_X    | SampleReady high, waiting for a sample
// WRITE_X  | write sample to X
// SETTLE   | datapath settle wait
// READ_REQ | read strobe to X address
// READ_CAP | capture Yn from ReadData
// PUSH_Y   | YValid high until YReady
// FINISH   | Done pulse, then IDLE
module fir_seq_ctrl
  import fir_pkg::*;
#(
  parameter int FIR_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               RstN,
  input  logic               Start,
  input  logic               Abort,
  input  logic [CNT_W-1:0]   NumSamples,
  input  logic [31:0]        CoefLo,
  input  logic [31:0]        CoefHi,
  input  logic [X_W-1:0]     SampleIn,
  input  logic               SampleValid,
  output logic               SampleReady,
  output logic [Y_W-1:0]     YOut,
  output logic               YValid,
  input  logic               YReady,
  output logic               Busy,
  output logic               Done,
  fir_seq_ctrl_if.master     csr
);

  localparam int TMR_W = (FIR_LAT > 1) ? $clog2(FIR_LAT) : 1;
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(FIR_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       coef_hi_q;
  logic              tmr_zero;
  logic              unused_rd;

  assign unused_rd = ^csr.ReadData[31:Y_W];

  fir_seq_timer #(.W(TMR_W)) u_timer (
    .clk     (clk),
    .RstN    (RstN),
    .Load    (state_d == WRITE_X),
    .LoadVal (SETTLE_LD),
    .Zero    (tmr_zero)
  );

  always_comb begin
    state_d = state_q;
    if (Abort && state_q != IDLE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     if (Start && !Abort) state_d = LOAD_LO;
        LOAD_LO:  state_d = LOAD_HI;
        LOAD_HI:  state_d = (cnt_q == '0) ? FINISH : GET_X;
        GET_X:    if (SampleValid) state_d = WRITE_X;
        // The timer is loaded as WRITE_X is entered, so it already counts
        // during WRITE_X; FIR_LAT == 1 needs no SETTLE cycle at all.
        WRITE_X:  state_d = (FIR_LAT == 1) ? READ_REQ : SETTLE;
        SETTLE:   if (tmr_zero) state_d = READ_REQ;
        READ_REQ: state_d = READ_CAP;
        READ_CAP: state_d = PUSH_Y;
        PUSH_Y:   if (YReady) state_d = (cnt_q == CNT_ONE) ? FINISH : GET_X;
        FINISH:   state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  assign SampleReady = (state_q == GET_X);

  // Bus and status outputs are decoded from the next state so that they are
  // registered yet line up with the state they belong to.
  always_ff @(posedge clk or negedge RstN) begin
    if (!RstN) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      coef_hi_q      <= '0;
      YOut           <= '0;
      YValid         <= 1'b0;
      Busy           <= 1'b0;
      Done           <= 1'b0;
      csr.ChipSelect <= 1'b0;
      csr.Write      <= 1'b0;
      csr.Read       <= 1'b0;
      csr.Address    <= '0;
      csr.WriteData  <= '0;
    end else begin
      state_q        <= state_d;
      Busy           <= (state_d != IDLE);
      Done           <= (state_d == FINISH);
      YValid         <= (state_d == PUSH_Y);
      csr.Write      <= (state_d == LOAD_LO) || (state_d == LOAD_HI) || (state_d == WRITE_X);
      csr.Read       <= (state_d == READ_REQ);
      csr.ChipSelect <= (state_d == LOAD_LO) || (state_d == LOAD_HI) ||
                        (state_d == WRITE_X) || (state_d == READ_REQ);

      case (state_d)
        LOAD_LO: begin
          csr.Address   <= ADDR_HLO;
          csr.WriteData <= CoefLo;
        end
        LOAD_HI: begin
          csr.Address   <= ADDR_HHI;
          csr.WriteData <= coef_hi_q;
        end
        WRITE_X: begin
          csr.Address   <= ADDR_X;
          csr.WriteData <= {{(32-X_W){1'b0}}, SampleIn};
        end
        READ_REQ: begin
          csr.Address   <= ADDR_X;
          csr.WriteData <= '0;
        end
        default: begin
          csr.Address   <= '0;
          csr.WriteData <= '0;
        end
      endcase

      if (state_q == IDLE && state_d == LOAD_LO) begin
        cnt_q     <= NumSamples;
        coef_hi_q <= CoefHi;
      end
      if (state_q == PUSH_Y && YReady && !Abort) begin
        cnt_q <= cnt_q - 1'b1;
      end

      if (state_q == READ_CAP && state_d == PUSH_Y) begin
        YOut <= csr.ReadData[Y_W-1:0];
      end
      if (Abort && state_q != IDLE) begin
        YOut <= '0;
      end
    end
  end

endmodule
